uart_mmio_fifo: RTL

- Parametrised memory-mapped bridge between the CPU bus and the uart_rx/uart_tx byte interfaces.
- Buffers received bytes in an RX FIFO and bytes to send in a TX FIFO, each of configurable depth.
- Drains the TX FIFO into uart_tx with a tx_busy handshake.
- Exposes data, status, control and level registers, plus a level-sensitive interrupt output.

---
 rtl/uart_mmio_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_mmio_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants for the UART MMIO bridge: register offsets, bit positions, TX FSM encoding.
package uart_mmio_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_LEVEL   = 2'd3;

  localparam int unsigned ST_RX_NOT_EMPTY = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_TX_EMPTY     = 2;
  localparam int unsigned ST_TX_FULL      = 3;
  localparam int unsigned ST_TX_BUSY      = 4;
  localparam int unsigned ST_RX_OVF       = 5;
  localparam int unsigned ST_TX_OVF       = 6;

  localparam int unsigned CT_RX_IRQ_EN = 0;
  localparam int unsigned CT_TX_IRQ_EN = 1;
  localparam int unsigned CT_RX_FLUSH  = 2;
  localparam int unsigned CT_TX_FLUSH  = 3;

  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_LAUNCH    = 2'd1;
  localparam logic [1:0] TX_WAIT_BUSY = 2'd2;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a push into a full FIFO succeeds only
// when a pop retires an entry in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// CPU-bus register bridge between uart_rx/uart_tx byte interfaces with RX/TX FIFOs,
// a TX launch FSM and a level interrupt.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BUS_W    = 32,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  write_data,
  input  logic              write_enable,
  input  logic              read_enable,
  output logic [BUS_W-1:0]  read_data,
  output logic              irq,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_busy
);

  localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

  logic [1:0]        reg_sel;
  logic              wr_data, wr_status, wr_ctrl, rd_data;
  logic              rx_flush, tx_flush, tx_pop;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic [BYTE_W-1:0] rx_dout, tx_dout;
  logic [RX_CW-1:0]  rx_count;
  logic [TX_CW-1:0]  tx_count;
  logic [BUS_W-1:0]  rd_mux;
  logic              unused_bits;

  logic [1:0]        state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              rx_ovf_q, rx_ovf_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic              irq_q, irq_d;
  logic [BUS_W-1:0]  read_data_q, read_data_d;

  assign unused_bits = ^{addr[ADDR_W-1:4], addr[1:0], write_data[BUS_W-1:BYTE_W]};

  assign reg_sel   = addr[3:2];
  assign wr_data   = write_enable & (reg_sel == REG_DATA);
  assign wr_status = write_enable & (reg_sel == REG_STATUS);
  assign wr_ctrl   = write_enable & (reg_sel == REG_CONTROL);
  assign rd_data   = read_enable  & (reg_sel == REG_DATA);
  assign rx_flush  = wr_ctrl & write_data[CT_RX_FLUSH];
  assign tx_flush  = wr_ctrl & write_data[CT_TX_FLUSH];

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_data_valid),
    .pop   (rd_data),
    .flush (rx_flush),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (write_data[BYTE_W-1:0]),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Read mux sees pre-write state, so a same-cycle write never leaks into read_data.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_DATA:    if (!rx_empty) rd_mux[BYTE_W-1:0] = rx_dout;
      REG_STATUS: begin
        rd_mux[ST_RX_NOT_EMPTY] = ~rx_empty;
        rd_mux[ST_RX_FULL]      = rx_full;
        rd_mux[ST_TX_EMPTY]     = tx_empty;
        rd_mux[ST_TX_FULL]      = tx_full;
        rd_mux[ST_TX_BUSY]      = tx_busy;
        rd_mux[ST_RX_OVF]       = rx_ovf_q;
        rd_mux[ST_TX_OVF]       = tx_ovf_q;
      end
      REG_CONTROL: begin
        rd_mux[CT_RX_IRQ_EN] = ctrl_q[CT_RX_IRQ_EN];
        rd_mux[CT_TX_IRQ_EN] = ctrl_q[CT_TX_IRQ_EN];
      end
      default: begin
        rd_mux[7:0]  = 8'(rx_count);
        rd_mux[15:8] = 8'(tx_count);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tx_pop      = 1'b0;
    tx_data_d   = tx_data_q;
    ctrl_d      = ctrl_q;
    rx_ovf_d    = rx_ovf_q;
    tx_ovf_d    = tx_ovf_q;
    read_data_d = read_data_q;

    case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy && !tx_flush) begin
          tx_pop  = 1'b1;
          state_d = TX_LAUNCH;
        end
      end
      TX_LAUNCH:    state_d = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (tx_busy)  state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase

    tx_valid_d = (state_d == TX_LAUNCH);
    if (tx_pop) tx_data_d = tx_dout;

    if (wr_ctrl) ctrl_d = {write_data[CT_TX_IRQ_EN], write_data[CT_RX_IRQ_EN]};

    // Setting wins over a same-cycle W1C so a fresh overflow is never lost.
    if (wr_status && write_data[ST_RX_OVF]) rx_ovf_d = 1'b0;
    if (wr_status && write_data[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (rx_data_valid && rx_full && !rd_data) rx_ovf_d = 1'b1;
    if (wr_data && tx_full && !tx_pop)        tx_ovf_d = 1'b1;

    if (read_enable) read_data_d = rd_mux;

    irq_d = (ctrl_q[CT_RX_IRQ_EN] & ~rx_empty) |
            (ctrl_q[CT_TX_IRQ_EN] & tx_empty & (state_q == TX_IDLE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= TX_IDLE;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      ctrl_q      <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      irq_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      ctrl_q      <= ctrl_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      irq_q       <= irq_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data     = read_data_q;
  assign irq           = irq_q;
  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;

endmodule
